// File: rtl/prm_edge_query_seq.sv
// prm_edge_query_seq: issues edge/voxel query runs to the checker bank,
// packs the 1-bit responses into words and counts hits.
// Optional early abort on first hit: define PRM_EARLY_ABORT_EN.
module prm_edge_query_seq #(
    parameter int QW      = 15,
    parameter int RES_W   = 32,
    parameter int CHK_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [QW-1:0]    base_code,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    chk_query,
    output logic             chk_query_vld,
    input  logic             chk_edge_mask,
    output logic [RES_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_last,
    output logic [CNT_W-1:0] hit_cnt
`ifdef PRM_EARLY_ABORT_EN
    ,
    output logic [CNT_W-1:0] first_hit_idx
`endif
);

    localparam int PW = (RES_W > 1) ? $clog2(RES_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [QW-1:0]    code_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] resp_idx_q;
    logic [CNT_W-1:0] hit_q;
    logic [RES_W-1:0] pack_q;
    logic [PW-1:0]    pos_q;
    logic             last_acc_q;

    logic [RES_W-1:0] mem_data [2];
    logic             mem_last [2];
    logic             rd_q;
    logic             wr_q;
    logic [1:0]       fcnt_q;

    logic             start_acc;
    logic             resp_fire;
    logic             dl_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic [RES_W-1:0] push_data;
    logic             push_last;
    logic             issue_fire;
    logic             issue_last;
    logic             issue_open_next;
    logic             final_resp;
    logic             word_full;
    logic             flush_push;
    logic [RES_W-1:0] full_word;
    logic [CNT_W:0]   total_after;
    logic             stop_now;
    logic             hit_or_abort;

`ifdef PRM_EARLY_ABORT_EN
    logic abort_q;
    logic hit_now;

    // A hit seen through the delay line stops issue in the same cycle;
    // with zero latency the stop can only take effect next cycle.
    assign hit_now      = resp_fire & chk_edge_mask;
    assign stop_now     = abort_q | (hit_now & (CHK_LAT != 0));
    assign hit_or_abort = abort_q | hit_now;
`else
    assign stop_now     = 1'b0;
    assign hit_or_abort = 1'b0;
`endif

    assign start_acc  = (state_q == IDLE) && start;
    assign fifo_full  = (fcnt_q == 2'd2);
    assign res_valid  = (fcnt_q != 2'd0);
    assign pop        = res_valid && res_ready;
    assign res_data   = res_valid ? mem_data[rd_q] : '0;
    assign res_last   = res_valid & mem_last[rd_q];

    assign issue_fire    = (state_q == ISSUE) && !fifo_full && !stop_now;
    assign chk_query_vld = issue_fire;
    assign chk_query     = code_q;
    assign issue_last    = ({1'b0, issued_q} + 1'b1) == {1'b0, cnt_q};

    // A response is the run's final one when nothing more can be issued
    // and it is the last of everything issued so far.
    assign total_after     = {1'b0, issued_q} + {{CNT_W{1'b0}}, issue_fire};
    assign issue_open_next = (state_q == ISSUE) && !hit_or_abort &&
                             !(issue_fire && issue_last);
    assign final_resp      = resp_fire && !issue_open_next &&
                             (({1'b0, resp_idx_q} + 1'b1) == total_after);

    assign word_full  = resp_fire && (pos_q == PW'(RES_W - 1));
    assign full_word  = pack_q | (RES_W'(chk_edge_mask) << pos_q);
    assign flush_push = (state_q == FLUSH) && (pos_q != '0) && !fifo_full;
    assign push       = word_full || flush_push;
    assign push_data  = word_full ? full_word : pack_q;
    assign push_last  = word_full ? final_resp : 1'b1;

    assign busy    = (state_q == ISSUE) || (state_q == DRAIN) ||
                     (state_q == FLUSH);
    assign done    = (state_q == DONE);
    assign hit_cnt = hit_q;

    generate
        if (CHK_LAT == 0) begin : g_lat0
            assign resp_fire = chk_query_vld;
            assign dl_empty  = 1'b1;
        end else begin : g_lat
            logic [CHK_LAT-1:0] dl_q;

            // Valid tags of queries in flight toward the checker bank.
            always_ff @(posedge CLK) begin
                if (RST) dl_q <= '0;
                else     dl_q <= (dl_q << 1) | CHK_LAT'(chk_query_vld);
            end

            assign resp_fire = dl_q[CHK_LAT-1];
            assign dl_empty  = (dl_q == '0);
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (start) state_d = (count == '0) ? DONE : ISSUE;
            ISSUE:
                if (stop_now || (issue_fire && issue_last)) state_d = DRAIN;
            DRAIN:
                if (dl_empty) state_d = FLUSH;
            FLUSH:
                if (last_acc_q || (pop && res_last)) state_d = DONE;
            DONE:
                state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    // Run bookkeeping: query code, counters, packer and final-word flag.
    always_ff @(posedge CLK) begin
        if (RST || start_acc) begin
            code_q     <= RST ? '0 : base_code;
            cnt_q      <= RST ? '0 : count;
            issued_q   <= '0;
            resp_idx_q <= '0;
            hit_q      <= '0;
            pack_q     <= '0;
            pos_q      <= '0;
            last_acc_q <= 1'b0;
        end else begin
            if (issue_fire) begin
                code_q   <= code_q + QW'(1);
                issued_q <= issued_q + CNT_W'(1);
            end
            if (resp_fire) begin
                resp_idx_q <= resp_idx_q + CNT_W'(1);
                if (chk_edge_mask && (hit_q != '1))
                    hit_q <= hit_q + CNT_W'(1);
                if (word_full) begin
                    pack_q <= '0;
                    pos_q  <= '0;
                end else begin
                    pack_q[pos_q] <= chk_edge_mask;
                    pos_q         <= pos_q + PW'(1);
                end
            end else if (flush_push) begin
                pack_q <= '0;
                pos_q  <= '0;
            end
            if (pop && res_last) last_acc_q <= 1'b1;
        end
    end

`ifdef PRM_EARLY_ABORT_EN
    // Remember the first hit of the run and stop issuing after it.
    always_ff @(posedge CLK) begin
        if (RST || start_acc) begin
            abort_q       <= 1'b0;
            first_hit_idx <= '1;
        end else if (hit_now && !abort_q) begin
            abort_q       <= 1'b1;
            first_hit_idx <= resp_idx_q;
        end
    end
`endif

    // Two-entry output FIFO; push and pop may coincide.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            fcnt_q <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_q] <= push_data;
                mem_last[wr_q] <= push_last;
                wr_q           <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            if (push && !pop)      fcnt_q <= fcnt_q + 2'd1;
            else if (pop && !push) fcnt_q <= fcnt_q - 2'd1;
        end
    end

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// tb_prm_edge_query_seq: directed and random runs checked against a
// word-level reference model of the query/pack behaviour.
module tb_prm_edge_query_seq;

`ifdef PRM_EARLY_ABORT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK;
    logic        RST;
    logic        start;
    logic [14:0] base_code;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [14:0] chk_query;
    logic        chk_query_vld;
    logic        chk_edge_mask;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        res_last;
    logic [15:0] hit_cnt;
`ifdef PRM_EARLY_ABORT_EN
    logic [15:0] first_hit_idx;
`endif

    prm_edge_query_seq #(
        .QW(15), .RES_W(32), .CHK_LAT(LAT), .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .base_code(base_code),
        .count(count),
        .busy(busy),
        .done(done),
        .chk_query(chk_query),
        .chk_query_vld(chk_query_vld),
        .chk_edge_mask(chk_edge_mask),
        .res_data(res_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_last(res_last),
        .hit_cnt(hit_cnt)
`ifdef PRM_EARLY_ABORT_EN
        ,
        .first_hit_idx(first_hit_idx)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [14:0] cur_mask = '0;
    logic        cur_inv = 1'b0;
    logic        cur_tgt_en = 1'b0;
    logic [14:0] cur_tgt = '0;
    int          rdy_mode = 0;

    logic [14:0] q_log [$];
    logic [32:0] w_log [$];
    int          done_cnt;
    int          any_valid;
    int          stab_err;

    function automatic logic f_resp(input logic [14:0] c);
        if (cur_tgt_en) return (c == cur_tgt);
        return (^(c & cur_mask)) ^ cur_inv;
    endfunction

    // Checker bank model: registered pipeline of LAT stages.
    logic       pend = 1'b0;
    logic [7:0] pipe = '0;
    always @(negedge CLK) pend = chk_query_vld ? f_resp(chk_query) : 1'b0;
    always @(posedge CLK) pipe <= {pipe[6:0], pend};
    assign chk_edge_mask = pipe[LAT-1];

    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom % 2);
            default: res_ready = 1'b0;
        endcase
    end

    // Monitor: log issued codes, accepted words, done pulses, stability.
    logic        prev_hold = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;
    always @(negedge CLK) begin
        if (chk_query_vld) q_log.push_back(chk_query);
        if (res_valid && res_ready) w_log.push_back({res_last, res_data});
        if (done) done_cnt++;
        if (res_valid) any_valid++;
        if (prev_hold && (!res_valid || res_data !== hold_data ||
                          res_last !== hold_last))
            stab_err++;
        prev_hold = res_valid && !res_ready;
        hold_data = res_data;
        hold_last = res_last;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        q_log.delete();
        w_log.delete();
        done_cnt  = 0;
        any_valid = 0;
        stab_err  = 0;
    endtask

    task automatic kick(input logic [14:0] b, input logic [15:0] c);
        @(posedge CLK);
        #1;
        start     = 1'b1;
        base_code = b;
        count     = c;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_query"}, chk_query, 0);
        chk({tag, "_qvld"}, chk_query_vld, 0);
        chk({tag, "_rvalid"}, res_valid, 0);
        chk({tag, "_rdata"}, res_data, 0);
        chk({tag, "_rlast"}, res_last, 0);
        chk({tag, "_hits"}, hit_cnt, 0);
    endtask

    // One run (count > 0) compared against the reference model.
    task automatic run_case(input logic [14:0] b, input logic [15:0] c,
                            input logic [14:0] m, input logic inv,
                            input int mode);
        int nw;
        int hits;
        int bad;
        logic [14:0] code;
        logic [32:0] ew;
        cur_mask   = m;
        cur_inv    = inv;
        cur_tgt_en = 1'b0;
        clear_logs();
        rdy_mode = mode;
        kick(b, c);
        if (mode == 2) begin
            repeat (200) @(posedge CLK);
            @(negedge CLK);
            chk("stall_issued", q_log.size(), 64 + LAT);
            chk("stall_qvld", chk_query_vld, 0);
            chk("stall_busy", busy, 1);
            chk("stall_done", done_cnt, 0);
            rdy_mode = 0;
        end
        wait_done(4000);
        chk("done_once", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("n_queries", q_log.size(), c);
        bad  = 0;
        hits = 0;
        for (int i = 0; i < c; i++) begin
            code = b + 15'(i);
            if (i < q_log.size() && q_log[i] !== code) bad++;
            if (f_resp(code)) hits++;
        end
        chk("query_codes", bad, 0);
        chk("hit_cnt", hit_cnt, hits);
        nw = (c + 31) / 32;
        chk("n_words", w_log.size(), nw);
        for (int k = 0; k < nw && k < w_log.size(); k++) begin
            ew = '0;
            ew[32] = (k == nw - 1);
            for (int j = 0; j < 32; j++)
                if (32 * k + j < c) ew[j] = f_resp(b + 15'(32 * k + j));
            chk("word", w_log[k], ew);
        end
        chk("res_stable", stab_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] rb;
        RST       = 1'b1;
        start     = 1'b0;
        base_code = '0;
        count     = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_vals("reset");
        RST = 1'b0;

`ifndef PRM_EARLY_ABORT_EN
        run_case(15'h0010, 16'd32, 15'h0001, 1'b0, 0);
        run_case(15'h7FFE, 16'd4, 15'h0000, 1'b1, 0);
`endif
        run_case(15'h1234, 16'd70, 15'h0000, 1'b0, 2);

        clear_logs();
        kick(15'h0100, 16'd0);
        wait_done(3);
        chk("empty_done", done_cnt, 1);
        chk("empty_valid", any_valid, 0);
        chk("empty_hits", hit_cnt, 0);
        chk("empty_queries", q_log.size(), 0);

        clear_logs();
        cur_mask = 15'h5A5A;
        cur_inv  = 1'b1;
        kick(15'h0200, 16'd40);
        for (int n = 0; n < 200 && q_log.size() < 10; n++) @(negedge CLK);
        chk("rst_reach", q_log.size(), 10);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_vals("midrst");
        RST = 1'b0;
`ifndef PRM_EARLY_ABORT_EN
        run_case(15'h0300, 16'd5, 15'h0007, 1'b1, 0);
        run_case(15'h7FF0, 16'd64, 15'($urandom), 1'b0, 1);
        for (int r = 0; r < 6; r++) begin
            rb = 15'($urandom);
            run_case(rb, 16'($urandom_range(1, 100)), 15'($urandom),
                     1'($urandom % 2), 1);
        end
`else
        run_case(15'h0300, 16'd5, 15'h0000, 1'b0, 0);
        clear_logs();
        cur_tgt_en = 1'b1;
        cur_tgt    = 15'h0407;
        rdy_mode   = 0;
        kick(15'h0400, 16'd100);
        wait_done(4000);
        chk("abort_done", done_cnt, 1);
        chk("abort_issued_ok", (q_log.size() >= 8 && q_log.size() <= 10), 1);
        chk("abort_idx", first_hit_idx, 7);
        chk("abort_hits", hit_cnt, 1);
        chk("abort_words", w_log.size(), 1);
        if (w_log.size() > 0) chk("abort_word", w_log[0], {1'b1, 32'h80});
        cur_tgt_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
